// File: rtl/fan_pkg.sv
// Shared constants, FSM state type and derived slope for the fan duty scheduler.
package fan_pkg;

    localparam int TEMP_W_DEF    = 8;
    localparam int DUTY_W_DEF    = 14;
    localparam int PERIOD_DEF    = 10000;
    localparam int DUTY_MIN_DEF  = 4000;
    localparam int DUTY_MAX_DEF  = 10000;
    localparam int T_LOW_DEF     = 40;
    localparam int T_HIGH_DEF    = 70;
    localparam int T_CRIT_DEF    = 85;
    localparam int HYST_DEF      = 3;
    localparam int RAMP_STEP_DEF = 100;
    localparam int RAMP_DIV_DEF  = 50000;
    localparam int TIMEOUT_DEF   = 2_000_000;

    typedef enum logic [1:0] {
        S_WAIT,
        S_CALC,
        S_APPLY
    } fan_state_e;

    // On-count added per degree between the two breakpoints (floored).
    function automatic int calc_slope(input int duty_min, input int duty_max,
                                      input int t_low, input int t_high);
        return (duty_max - duty_min) / (t_high - t_low);
    endfunction

endpackage

// File: rtl/fan_ramp.sv
// Duty stepper: free-running prescaler, fixed-step ramp toward the target,
// and an immediate jump to full duty.
module fan_ramp
    import fan_pkg::*;
#(
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int RAMP_DIV  = RAMP_DIV_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jump,
    input  logic [DUTY_W-1:0] target,
    input  logic [DUTY_W-1:0] target_nxt,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_update,
    output logic              at_target
);

    localparam int                PRE_W  = $clog2(RAMP_DIV);
    localparam logic [PRE_W-1:0]  PRE_TC = PRE_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] DMAX_V = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(RAMP_STEP);
    localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(RAMP_STEP);

    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [DUTY_W-1:0] duty_nxt;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   gap;

    assign tick = (pre_cnt == PRE_TC);

    // Prescaler: counts 0..RAMP_DIV-1, tick on terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // Next duty: jump wins, otherwise one clamped step toward the registered target.
    always_comb begin
        duty_nxt = duty_o;
        up_sum   = {1'b0, duty_o} + STEP_X;
        gap      = '0;
        if (jump) begin
            duty_nxt = DMAX_V;
        end else if (tick) begin
            if (duty_o < target) begin
                duty_nxt = (up_sum >= {1'b0, target}) ? target : up_sum[DUTY_W-1:0];
            end else if (duty_o > target) begin
                gap      = {1'b0, duty_o - target};
                duty_nxt = (gap <= STEP_X) ? target : duty_o - STEP_V;
            end
        end
    end

    // Duty register with change pulse and target-match flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_o      <= DMAX_V;
            duty_update <= 1'b0;
            at_target   <= 1'b1;
        end else begin
            duty_o      <= duty_nxt;
            duty_update <= (duty_nxt != duty_o);
            at_target   <= (duty_nxt == target_nxt);
        end
    end

endmodule

// File: rtl/fan_duty_sched.sv
// Thermal duty scheduler: sample intake FSM, temperature-to-target mapping
// with hysteresis, over-temperature and sensor-timeout failsafes.
//
// state   | meaning
// S_WAIT  | ready for a sample; handshake captures temperature
// S_CALC  | map captured temperature to a raw on-count
// S_APPLY | hysteresis/overtemp decision, write target
module fan_duty_sched
    import fan_pkg::*;
#(
    parameter int TEMP_W    = TEMP_W_DEF,
    parameter int DUTY_W    = DUTY_W_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int DUTY_MIN  = DUTY_MIN_DEF,
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int T_LOW     = T_LOW_DEF,
    parameter int T_HIGH    = T_HIGH_DEF,
    parameter int T_CRIT    = T_CRIT_DEF,
    parameter int HYST      = HYST_DEF,
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int RAMP_DIV  = RAMP_DIV_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    output logic              temp_ready,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_update,
    output logic              at_target,
    output logic              overtemp,
    output logic              stale
);

    // Never command more on-time than the PWM period holds.
    localparam int DUTY_CAP = (DUTY_MAX < PERIOD) ? DUTY_MAX : PERIOD;
    localparam int SLOPE    = calc_slope(DUTY_MIN, DUTY_MAX, T_LOW, T_HIGH);
    localparam int PW       = TEMP_W + DUTY_W;
    localparam int HW       = TEMP_W + 2;
    localparam int TO_W     = $clog2(TIMEOUT + 1);

    localparam logic [DUTY_W-1:0] DMAX_V   = DUTY_W'(DUTY_CAP);
    localparam logic [DUTY_W-1:0] DMIN_V   = DUTY_W'(DUTY_MIN);
    localparam logic [TEMP_W-1:0] T_LOW_V  = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] T_HIGH_V = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] T_CRIT_V = TEMP_W'(T_CRIT);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

    fan_state_e        state, state_nxt;
    logic              hs;
    logic [TEMP_W-1:0] temp_q;
    logic [TEMP_W-1:0] last_temp, last_nxt;
    logic [DUTY_W-1:0] raw_q, raw_nxt;
    logic [DUTY_W-1:0] target_q, target_nxt;
    logic [PW-1:0]     prod, sum;
    logic [HW-1:0]     hyst_sum;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic              ovt_nxt, stale_nxt, jump;

    assign hs = temp_valid & temp_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_WAIT;
        else
            state <= state_nxt;
    end

    // Next state and ready: one sample in flight, accepted only while waiting.
    always_comb begin
        state_nxt  = state;
        temp_ready = 1'b0;
        unique case (state)
            S_WAIT: begin
                temp_ready = 1'b1;
                if (temp_valid)
                    state_nxt = S_CALC;
            end
            S_CALC:  state_nxt = S_APPLY;
            S_APPLY: state_nxt = S_WAIT;
            default: state_nxt = S_WAIT;
        endcase
    end

    // Piecewise-linear temperature to on-count map, clamped to full duty.
    always_comb begin
        prod = PW'(temp_q - T_LOW_V) * PW'(SLOPE);
        sum  = prod + PW'(DUTY_MIN);
        if (temp_q <= T_LOW_V)
            raw_nxt = DMIN_V;
        else if (temp_q >= T_HIGH_V)
            raw_nxt = DMAX_V;
        else if (sum > PW'(DUTY_CAP))
            raw_nxt = DMAX_V;
        else
            raw_nxt = sum[DUTY_W-1:0];
    end

    // Timeout, overtemp and hysteresis decisions; failsafe jump overrides the target write.
    always_comb begin
        to_nxt     = to_cnt;
        stale_nxt  = stale;
        ovt_nxt    = overtemp;
        target_nxt = target_q;
        last_nxt   = last_temp;
        jump       = 1'b0;
        hyst_sum   = {2'b00, temp_q} + HW'(HYST);

        if (hs) begin
            to_nxt    = '0;
            stale_nxt = 1'b0;
        end else if (to_cnt != TO_MAX) begin
            to_nxt = to_cnt + TO_W'(1);
            if (to_nxt == TO_MAX) begin
                stale_nxt = 1'b1;
                jump      = 1'b1;
            end
        end

        if (state == S_APPLY) begin
            if (temp_q >= T_CRIT_V) begin
                ovt_nxt = 1'b1;
                jump    = 1'b1;
            end else if (overtemp && (hyst_sum < {2'b00, T_CRIT_V})) begin
                ovt_nxt = 1'b0;
            end

            if (ovt_nxt) begin
                target_nxt = DMAX_V;
                last_nxt   = temp_q;
            end else if (raw_q >= target_q) begin
                target_nxt = raw_q;
                last_nxt   = temp_q;
            end else if (hyst_sum <= {2'b00, last_temp}) begin
                target_nxt = raw_q;
                last_nxt   = temp_q;
            end
        end

        if (jump)
            target_nxt = DMAX_V;
    end

    // Sample capture, raw pipeline stage, target and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            temp_q    <= '0;
            raw_q     <= DMAX_V;
            target_q  <= DMAX_V;
            last_temp <= '1;
            overtemp  <= 1'b0;
            stale     <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (hs)
                temp_q <= temp_data;
            if (state == S_CALC)
                raw_q <= raw_nxt;
            target_q  <= target_nxt;
            last_temp <= last_nxt;
            overtemp  <= ovt_nxt;
            stale     <= stale_nxt;
            to_cnt    <= to_nxt;
        end
    end

    fan_ramp #(
        .DUTY_W    (DUTY_W),
        .DUTY_MAX  (DUTY_CAP),
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
    ) u_ramp (
        .clk         (clk),
        .reset       (reset),
        .jump        (jump),
        .target      (target_q),
        .target_nxt  (target_nxt),
        .duty_o      (duty_o),
        .duty_update (duty_update),
        .at_target   (at_target)
    );

endmodule

// File: tb/tb_fan_duty_sched.sv
// Bench for fan_duty_sched: directed scenarios plus random samples, every
// cycle compared against an event-level reference model of the scheduler.
module tb_fan_duty_sched;

    localparam int RDIV  = 8;
    localparam int TOUT  = 200;
    localparam int DMIN  = 4000;
    localparam int DMAX  = 10000;
    localparam int TLOW  = 40;
    localparam int THIGH = 70;
    localparam int TCRIT = 85;
    localparam int HYST  = 3;
    localparam int STEP  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        temp_valid;
    logic [7:0]  temp_data;
    logic        temp_ready;
    logic [13:0] duty_o;
    logic        duty_update;
    logic        at_target;
    logic        overtemp;
    logic        stale;

    int n_chk = 0;
    int n_err = 0;

    fan_duty_sched #(
        .RAMP_DIV (RDIV),
        .TIMEOUT  (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .temp_valid  (temp_valid),
        .temp_data   (temp_data),
        .temp_ready  (temp_ready),
        .duty_o      (duty_o),
        .duty_update (duty_update),
        .at_target   (at_target),
        .overtemp    (overtemp),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int raw_of(input int t);
        int v;
        if (t <= TLOW)
            return DMIN;
        if (t >= THIGH)
            return DMAX;
        v = DMIN + (t - TLOW) * ((DMAX - DMIN) / (THIGH - TLOW));
        return (v > DMAX) ? DMAX : v;
    endfunction

    // Reference model state, advanced once per clock edge.
    int m_k, m_last_hs, m_apply_k, m_pend, m_tgt, m_duty, m_last;
    bit m_ovt, m_stale, m_upd, m_ready;

    always @(posedge clk or posedge reset) begin
        int  old_tgt, old_duty, t, r;
        bit  jmp;
        if (reset) begin
            m_k = 0; m_last_hs = 0; m_apply_k = 0; m_pend = 0;
            m_tgt = DMAX; m_duty = DMAX; m_last = 255;
            m_ovt = 0; m_stale = 0; m_upd = 0; m_ready = 1;
        end else begin
            m_k++;
            jmp      = 0;
            old_tgt  = m_tgt;
            old_duty = m_duty;
            if (temp_valid && m_ready) begin
                m_last_hs = m_k;
                m_stale   = 0;
                m_pend    = int'(temp_data);
                m_apply_k = m_k + 2;
            end else if (m_k - m_last_hs == TOUT) begin
                m_stale = 1;
                jmp     = 1;
            end
            if (m_k == m_apply_k) begin
                t = m_pend;
                r = raw_of(t);
                if (t >= TCRIT) begin
                    m_ovt = 1;
                    jmp   = 1;
                end else if (m_ovt && t + HYST < TCRIT) begin
                    m_ovt = 0;
                end
                if (m_ovt) begin
                    m_tgt = DMAX; m_last = t;
                end else if (r >= old_tgt || t + HYST <= m_last) begin
                    m_tgt = r; m_last = t;
                end
            end
            if (jmp) begin
                m_tgt  = DMAX;
                m_duty = DMAX;
            end else if (m_k % RDIV == 0) begin
                if (m_duty < old_tgt)
                    m_duty = (m_duty + STEP > old_tgt) ? old_tgt : m_duty + STEP;
                else if (m_duty > old_tgt)
                    m_duty = (m_duty - STEP < old_tgt) ? old_tgt : m_duty - STEP;
            end
            m_upd   = (m_duty != old_duty);
            m_ready = (m_k >= m_apply_k);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("duty", int'(duty_o), m_duty);
        chk("at_target", int'(at_target), int'(m_duty == m_tgt));
        chk("duty_update", int'(duty_update), int'(m_upd));
        chk("overtemp", int'(overtemp), int'(m_ovt));
        chk("stale", int'(stale), int'(m_stale));
        chk("temp_ready", int'(temp_ready), int'(m_ready));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input int t);
        bit got;
        got        = 0;
        temp_valid = 1'b1;
        temp_data  = 8'(t);
        for (int i = 0; i < 20; i++) begin
            if (temp_ready) begin
                got = 1;
                step(1);
                break;
            end
            step(1);
        end
        temp_valid = 1'b0;
        chk("accept_bound", int'(got), 1);
    endtask

    // Keep the sensor alive with a constant temperature for roughly n cycles.
    task automatic hold(input int t, input int n);
        int left;
        left = n;
        while (left > 0) begin
            send(t);
            step(60);
            left -= 61;
        end
    endtask

    initial begin
        int acc;
        reset      = 1'b1;
        temp_valid = 1'b0;
        temp_data  = '0;
        step(3);
        chk("rst_duty", int'(duty_o), DMAX);
        chk("rst_ready", int'(temp_ready), 1);
        chk("rst_at_target", int'(at_target), 1);
        chk("rst_update", int'(duty_update), 0);
        chk("rst_overtemp", int'(overtemp), 0);
        chk("rst_stale", int'(stale), 0);
        reset = 1'b0;

        // Post-reset ramp down to 7000.
        send(55);
        hold(55, 260);
        chk("ramp_down_duty", int'(duty_o), 7000);
        chk("ramp_down_at", int'(at_target), 1);

        // Hysteresis.
        hold(60, 150);
        chk("hyst_60", int'(duty_o), 8000);
        hold(58, 100);
        chk("hyst_58_held", int'(duty_o), 8000);
        hold(57, 100);
        chk("hyst_57", int'(duty_o), 7400);

        // Increases are never held off.
        hold(65, 200);
        chk("rise_65", int'(duty_o), 9000);

        // Over-temperature.
        send(85);
        step(1);
        chk("ovt_before_e2", int'(overtemp), 0);
        step(1);
        chk("ovt_set", int'(overtemp), 1);
        chk("ovt_duty", int'(duty_o), DMAX);
        chk("ovt_update", int'(duty_update), 1);
        send(82);
        step(3);
        chk("ovt_82_held", int'(overtemp), 1);
        send(81);
        step(3);
        chk("ovt_81_clear", int'(overtemp), 0);
        chk("ovt_81_duty", int'(duty_o), DMAX);
        chk("ovt_81_at", int'(at_target), 1);

        // Sensor timeout, then a handshake on the expiry edge.
        send(50);
        step(205);
        chk("stale_set", int'(stale), 1);
        chk("stale_duty", int'(duty_o), DMAX);
        send(60);
        step(199);
        send(62);
        step(2);
        chk("stale_hs_wins", int'(stale), 0);

        // Backpressure: valid held high with changing data.
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            temp_data  = 8'($urandom_range(30, 90));
            temp_valid = 1'b1;
            if (temp_ready)
                acc++;
            step(1);
        end
        temp_valid = 1'b0;
        chk("backpressure_accepts", acc, 10);
        step(5);

        // Reset while a sample is in S_CALC.
        hold(45, 450);
        send(50);
        #2 reset = 1'b1;
        #1;
        chk("midrst_duty", int'(duty_o), DMAX);
        chk("midrst_at", int'(at_target), 1);
        chk("midrst_ready", int'(temp_ready), 1);
        chk("midrst_update", int'(duty_update), 0);
        step(1);
        reset = 1'b0;
        step(12);
        chk("midrst_dropped_duty", int'(duty_o), DMAX);
        chk("midrst_dropped_at", int'(at_target), 1);

        // Random samples and gaps.
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(25, 95)));
            step(int'($urandom_range(0, 120)));
        end
        step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fan_duty_sched.md
# fan_duty_sched

Thermal duty scheduler feeding the fan PWM stage. It accepts temperature samples over a valid/ready handshake and maps each sample to a target on-count with hysteresis. It ramps the output duty toward that target in fixed steps, and forces full speed on over-temperature or sensor silence. `duty_o` drives the on-count compare of the downstream PWM generator, whose period is `PERIOD` cycles.

## Interface
- `TEMP_W`, 8: temperature sample width, unsigned °C.
- `DUTY_W`, 14: duty/on-count width. Requires `PERIOD < 2**DUTY_W`.
- `PERIOD`, 10000: PWM period in cycles. Requires `DUTY_MAX <= PERIOD`.
- `DUTY_MIN`, 4000: on-count at or below `T_LOW`.
- `DUTY_MAX`, 10000: on-count at or above `T_HIGH`; also the failsafe value.
- `T_LOW`, 40: lower temperature breakpoint.
- `T_HIGH`, 70: upper temperature breakpoint. Requires `T_HIGH > T_LOW`.
- `T_CRIT`, 85: over-temperature threshold.
- `HYST`, 3: hysteresis in °C.
- `RAMP_STEP`, 100: on-count change per ramp tick.
- `RAMP_DIV`, 50000: cycles between ramp ticks. Requires `RAMP_DIV >= 2`.
- `TIMEOUT`, 2_000_000: cycles without an accepted sample before the block declares the sensor stale.
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `temp_valid`, in, 1: sample valid.
- `temp_data`, in, `TEMP_W`: sample value.
- `temp_ready`, out, 1: block can accept a sample.
- `duty_o`, out, `DUTY_W`: on-count sent to the PWM stage.
- `duty_update`, out, 1: one-cycle pulse on every change of `duty_o`.
- `at_target`, out, 1: `duty_o == target`.
- `overtemp`, out, 1: over-temperature flag.
- `stale`, out, 1: sensor timeout flag.

## Operation
- **Reset values:**
  - `duty_o` = target = `DUTY_MAX`. The fan runs at full speed until the first sample arrives.
  - `temp_ready` = 1, `at_target` = 1.
  - `duty_update`, `overtemp`, `stale` = 0.
  - `last_temp` = all-ones.
  - Prescaler and timeout counters = 0.
- **FSM states:**
  - `S_WAIT`: `temp_ready` = 1. A handshake (`temp_valid & temp_ready`) captures `temp_data` and moves to `S_CALC`.
  - `S_CALC`: `temp_ready` = 0. Computes the raw target:
    - `temp <= T_LOW` → `DUTY_MIN`.
    - `temp >= T_HIGH` → `DUTY_MAX`.
    - Otherwise `DUTY_MIN + (temp - T_LOW) * SLOPE`, where `SLOPE = (DUTY_MAX - DUTY_MIN) / (T_HIGH - T_LOW)` with integer floor.
    - The product is computed at `TEMP_W + DUTY_W` bits, then clamped to `DUTY_MAX`.
  - `S_APPLY`: `temp_ready` = 0. Applies hysteresis, then returns to `S_WAIT`:
    - If raw ≥ target: target := raw and `last_temp` := temp.
    - If raw < target: apply only when `temp + HYST <= last_temp`; otherwise both are unchanged.
- **Over-temperature:**
  - In `S_APPLY`, `temp >= T_CRIT` sets `overtemp`, and target and `duty_o` jump to `DUTY_MAX` on the same edge.
  - `overtemp` clears in `S_APPLY` when `temp + HYST < T_CRIT`.
  - While `overtemp` = 1, the target stays at `DUTY_MAX`.
- **Ramp:**
  - The prescaler free-runs from 0 to `RAMP_DIV-1` and ticks on the terminal count.
  - On a tick with `duty_o < target`: `duty_o` := min(`duty_o + RAMP_STEP`, target).
  - On a tick with `duty_o > target`: `duty_o` := max(`duty_o - RAMP_STEP`, target).
  - The comparison uses widened arithmetic and must not wrap.
- **Timeout:**
  - The timeout counter clears on every handshake and saturates at `TIMEOUT`.
  - On reaching `TIMEOUT`: `stale` = 1, and target and `duty_o` jump to `DUTY_MAX`.
  - `stale` clears on the next handshake; that sample then goes through normal processing.
- **Priority on a single edge, highest first:** overtemp/stale jump, then the `S_APPLY` target write, then the ramp step.
  - The ramp step always compares against the registered (old) target.
  - A handshake on the same edge the counter would reach `TIMEOUT` wins; `stale` is not set.
- **Reset mid-operation:** all state returns to the reset values immediately and asynchronously. A sample in `S_CALC` or `S_APPLY` is discarded.

## Timing
- Handshake at edge E0. `S_CALC` runs during cycle E0–E1, `S_APPLY` during E1–E2.
- The target register, `overtemp` and any jump of `duty_o` update at E2. `temp_ready` returns to 1 in the cycle after E2.
- Minimum sample spacing: 3 cycles.
- `duty_update` is high in the cycle following any edge that changed `duty_o`.
- `at_target` is registered alongside `duty_o` and target.
- `duty_o` changes only on ramp ticks, jump edges, or reset.

## Structure
- Package `fan_pkg`:
  - Default parameter constants.
  - State enum `{S_WAIT, S_CALC, S_APPLY}`.
  - A derived `SLOPE` function.
- Sub-module `fan_ramp`:
  - Contains the prescaler, the stepper toward target, and the jump input.
  - Owns `duty_o`, `duty_update` and `at_target`.
- The top level holds the FSM, the target computation, hysteresis, overtemp and the timeout counter.

## Test plan
Unless a line says otherwise, benches use `RAMP_DIV`=8, `TIMEOUT`=200 and all other parameters at default.

- **Post-reset ramp down:** reset, then send temp 55 → target 7000 at E2. `duty_o` falls by 100 per tick, 10000 → 7000 over 30 ticks, then `at_target`=1.
- **Hysteresis:** send temp 60 → target 8000. Temp 58 → target unchanged at 8000. Temp 57 → target 7400.
- **Immediate increase:** from target 7000, send temp 65 → target 9000 at E2. Ramp climbs 100 per tick; an increase is never held off by hysteresis.
- **Over-temperature:** send temp 85 → `overtemp`=1 and `duty_o`=10000 on the same edge. Temp 82 keeps `overtemp`=1. Temp 81 clears it, and target becomes `DUTY_MAX` clamped (temp ≥ `T_HIGH`).
- **Sensor timeout:** send no samples for 200 cycles → `stale`=1 and `duty_o`=10000. A handshake on the expiry edge leaves `stale`=0.
- **Backpressure and reset mid-op:**
  - Hold `temp_valid` high with changing data. Exactly one sample is accepted per 3 cycles, and `temp_ready`=0 for two cycles after each accept.
  - Assert `reset` during `S_CALC`. All outputs return to their reset values and the in-flight sample is dropped.
